// File: rtl/adc_spi_master_if.sv
// ----------------------------------------------------------------------------
// adc_spi_master_if : request handshake and SPI pins of the ADC sample-frame master
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface adc_spi_master_if;
  logic        start;
  logic [9:0]  sample;
  logic [3:0]  sample_channel;
  logic        busy;
  logic        done;
  logic [15:0] rx_data;
  logic        spi_ss;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso;

  modport master (
    input  start, sample, sample_channel, spi_miso,
    output busy, done, rx_data, spi_ss, spi_sck, spi_mosi
  );

  modport slave (
    output start, sample, sample_channel, spi_miso,
    input  busy, done, rx_data, spi_ss, spi_sck, spi_mosi
  );
endinterface

`default_nettype wire

// File: rtl/adc_spi_master.sv
// ----------------------------------------------------------------------------
// adc_spi_master : SPI mode-0 master sending 2-byte {sample, channel} frames;
// MISO capture into rx_data is built only with ADC_SPI_MISO_CAPTURE_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module adc_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int DIV_SIZE = 3,
  parameter int SS_GAP   = 8,
  parameter int GAP_SIZE = 4
) (
  input  logic             clk,
  input  logic             rst,
  adc_spi_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  localparam logic [DIV_SIZE-1:0] DIV_LAST = DIV_SIZE'(CLK_DIV - 1);
  localparam logic [GAP_SIZE-1:0] GAP_LAST = GAP_SIZE'(SS_GAP - 1);

  state_t              state;
  logic [DIV_SIZE-1:0] div_cnt;
  logic [GAP_SIZE-1:0] gap_cnt;
  logic [3:0]          bit_cnt;
  logic [15:0]         tx_shift;
  logic                ss;
  logic                sck;
  logic                mosi;
  logic                busy;
  logic                done;

  logic div_end;
  logic sck_rise;
  logic frame_end;

  assign div_end   = (div_cnt == DIV_LAST);
  // Edges that raise sck: end of setup, or end of a low phase that is not the last bit.
  assign sck_rise  = div_end && ((state == SETUP) ||
                                 (state == XFER && !sck && bit_cnt != 4'd15));
  assign frame_end = div_end && (state == HOLD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      gap_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      ss       <= 1'b1;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            tx_shift <= {bus.sample[7:0], bus.sample_channel, 2'b00, bus.sample[9:8]};
            mosi     <= bus.sample[7];
            ss       <= 1'b0;
            busy     <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (sck_rise) begin
            div_cnt <= '0;
            sck     <= 1'b1;
            state   <= XFER;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        XFER: begin
          if (!div_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (sck) begin
              sck      <= 1'b0;
              tx_shift <= {tx_shift[14:0], 1'b0};
              mosi     <= tx_shift[14];
            end else if (sck_rise) begin
              sck     <= 1'b1;
              bit_cnt <= bit_cnt + 4'd1;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (frame_end) begin
            ss      <= 1'b1;
            mosi    <= 1'b0;
            done    <= 1'b1;
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.spi_ss   = ss;
  assign bus.spi_sck  = sck;
  assign bus.spi_mosi = mosi;
  assign bus.busy     = busy;
  assign bus.done     = done;

`ifdef ADC_SPI_MISO_CAPTURE_EN
  logic [15:0] rx_shift;
  logic [15:0] rx_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_shift <= '0;
      rx_data  <= '0;
    end else begin
      if (sck_rise) rx_shift <= {rx_shift[14:0], bus.spi_miso};
      if (frame_end) rx_data <= rx_shift;
    end
  end

  assign bus.rx_data = rx_data;
`else
  logic unused_miso;
  assign unused_miso = bus.spi_miso;
  assign bus.rx_data = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adc_spi_master.sv
// ----------------------------------------------------------------------------
// tb_adc_spi_master : directed + randomized frames checked against a frame-level model
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_adc_spi_master;

  localparam int A_DIV = 4;
  localparam int A_GAP = 8;
  localparam int B_DIV = 1;
  localparam int B_GAP = 1;

`ifdef ADC_SPI_MISO_CAPTURE_EN
  localparam logic [15:0] RX_MASK = 16'hFFFF;
`else
  localparam logic [15:0] RX_MASK = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adc_spi_master_if a_if ();
  adc_spi_master_if b_if ();

  adc_spi_master #(.CLK_DIV(A_DIV), .DIV_SIZE(3), .SS_GAP(A_GAP), .GAP_SIZE(4))
    u_a (.clk(clk), .rst(rst), .bus(a_if.master));
  adc_spi_master #(.CLK_DIV(B_DIV), .DIV_SIZE(1), .SS_GAP(B_GAP), .GAP_SIZE(1))
    u_b (.clk(clk), .rst(rst), .bus(b_if.master));

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [15:0] mosi;
    int          rises;
    int          ss_low;
    int          done_lat;
    int          dones;
    int          busy_tail;
  } frame_res_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] frame_word(input logic [9:0] s, input logic [3:0] c);
    return {s[7:0], c, 2'b00, s[9:8]};
  endfunction

  // Drives one start pulse on instance A and acts as SPI slave until busy drops.
  task automatic run_frame(input logic [9:0] smp, input logic [3:0] ch, input logic [15:0] slave,
                           input int poke_bit, output frame_res_t r);
    logic prev_sck;
    bit   poked;
    int   done_cyc;
    prev_sck = 1'b0;
    poked    = 1'b0;
    done_cyc = -1;
    r = '{16'h0000, 0, 0, -1, 0, -1};
    @(negedge clk);
    a_if.sample = smp;
    a_if.sample_channel = ch;
    a_if.start = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        a_if.sample = 10'($urandom);
        a_if.sample_channel = 4'($urandom);
      end
      a_if.start = 1'b0;
      if (!a_if.spi_ss) r.ss_low++;
      if (a_if.spi_sck && !prev_sck) begin
        r.mosi = {r.mosi[14:0], a_if.spi_mosi};
        r.rises++;
      end
      prev_sck = a_if.spi_sck;
      if (!a_if.spi_sck) a_if.spi_miso = (r.rises < 16) ? slave[15 - r.rises] : 1'b0;
      if (poke_bit >= 0 && !poked && r.rises == poke_bit) begin
        a_if.start = 1'b1;
        a_if.sample = 10'($urandom);
        poked = 1'b1;
      end
      if (a_if.done) begin
        r.dones++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          r.done_lat = cyc;
        end
      end
      if (done_cyc >= 0 && !a_if.busy) begin
        r.busy_tail = cyc - done_cyc;
        break;
      end
    end
    a_if.start = 1'b0;
    a_if.spi_miso = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [9:0] s, input logic [3:0] c,
                             input logic [15:0] slave, input frame_res_t r);
    check({tag, ".mosi"}, r.mosi, frame_word(s, c));
    check({tag, ".sck_pulses"}, r.rises, 16);
    check({tag, ".ss_low"}, r.ss_low, 34 * A_DIV);
    check({tag, ".done_lat"}, r.done_lat, 34 * A_DIV + 1);
    check({tag, ".done_count"}, r.dones, 1);
    check({tag, ".busy_tail"}, r.busy_tail, A_GAP);
    check({tag, ".rx_data"}, a_if.rx_data, slave & RX_MASK);
  endtask

  initial begin
    frame_res_t  r;
    logic [9:0]  s;
    logic [3:0]  c;
    logic [15:0] sl;
    logic        prev;
    int          rises;
    bit          bad_idle;
    bit          saw_done;
    int          dcyc[$];
    int          ss_runs[$];
    int          busy_runs[$];
    int          hi_run;
    int          lo_run;
    bit          seen_low;

    a_if.start = 0; a_if.sample = '0; a_if.sample_channel = '0; a_if.spi_miso = 0;
    b_if.start = 0; b_if.sample = '0; b_if.sample_channel = '0; b_if.spi_miso = 0;

    // Reset then 20 idle cycles
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bad_idle = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (a_if.spi_ss !== 1'b1 || a_if.spi_sck !== 1'b0 || a_if.busy !== 1'b0 ||
          a_if.done !== 1'b0 || a_if.spi_mosi !== 1'b0) bad_idle = 1'b1;
    end
    check("idle.outputs_quiet", bad_idle, 1'b0);
    check("idle.rx_data", a_if.rx_data, 16'h0000);

    // Directed frame with an idle slave, then with a 0xFF3C slave
    run_frame(10'h2A5, 4'h9, 16'h0000, -1, r);
    check_frame("f2A5", 10'h2A5, 4'h9, 16'h0000, r);
    run_frame(10'h2A5, 4'h9, 16'hFF3C, -1, r);
    check_frame("f2A5_miso", 10'h2A5, 4'h9, 16'hFF3C, r);
    repeat (10) @(negedge clk);
    check("rx_hold", a_if.rx_data, 16'hFF3C & RX_MASK);

    // Start pulsed during bit 3 must be ignored
    run_frame(10'h15A, 4'h3, 16'hA55A, 3, r);
    check_frame("poke", 10'h15A, 4'h3, 16'hA55A, r);
    saw_done = 1'b0;
    bad_idle = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (a_if.done) saw_done = 1'b1;
      if (!a_if.spi_ss || a_if.busy) bad_idle = 1'b1;
    end
    check("poke.no_second_done", saw_done, 1'b0);
    check("poke.no_second_frame", bad_idle, 1'b0);

    // Randomized frames
    for (int i = 0; i < 3; i++) begin
      s = 10'($urandom);
      c = 4'($urandom);
      sl = 16'($urandom);
      run_frame(s, c, sl, -1, r);
      check_frame($sformatf("rand%0d", i), s, c, sl, r);
    end

    // Asynchronous reset during bit 5
    @(negedge clk);
    a_if.sample = 10'h0F0; a_if.sample_channel = 4'h5; a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    rises = 0;
    prev = a_if.spi_sck;
    for (int cyc = 0; cyc < 300 && rises < 5; cyc++) begin
      @(negedge clk);
      if (a_if.spi_sck && !prev) rises++;
      prev = a_if.spi_sck;
    end
    check("areset.reached_bit5", rises, 5);
    #2 rst = 1'b0;
    #1;
    check("areset.ss", a_if.spi_ss, 1'b1);
    check("areset.sck", a_if.spi_sck, 1'b0);
    check("areset.busy", a_if.busy, 1'b0);
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (a_if.done !== 1'b0) saw_done = 1'b1;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (a_if.done !== 1'b0) saw_done = 1'b1;
    end
    check("areset.no_done", saw_done, 1'b0);
    run_frame(10'h3FF, 4'hF, 16'h0000, -1, r);
    check_frame("after_reset", 10'h3FF, 4'hF, 16'h0000, r);

    // Back-to-back frames on the fast instance with start held high
    hi_run = 0;
    lo_run = 0;
    seen_low = 1'b0;
    @(negedge clk);
    b_if.sample = 10'($urandom);
    b_if.sample_channel = 4'($urandom);
    b_if.start = 1'b1;
    for (int cyc = 1; cyc <= 300 && dcyc.size() < 3; cyc++) begin
      @(negedge clk);
      if (b_if.done) dcyc.push_back(cyc);
      if (b_if.spi_ss) hi_run++;
      else begin
        if (seen_low && hi_run > 0) ss_runs.push_back(hi_run);
        hi_run = 0;
        seen_low = 1'b1;
      end
      if (!b_if.busy) lo_run++;
      else begin
        if (lo_run > 0) busy_runs.push_back(lo_run);
        lo_run = 0;
      end
    end
    b_if.start = 1'b0;
    check("b2b.done_count", dcyc.size(), 3);
    check("b2b.first_done_lat", (dcyc.size() > 0) ? dcyc[0] : -1, 34 * B_DIV + 1);
    check("b2b.spacing01", (dcyc.size() > 1) ? dcyc[1] - dcyc[0] : -1, 34 * B_DIV + B_GAP + 1);
    check("b2b.spacing12", (dcyc.size() > 2) ? dcyc[2] - dcyc[1] : -1, 34 * B_DIV + B_GAP + 1);
    check("b2b.ss_high_runs", ss_runs.size(), 2);
    check("b2b.ss_high_len", (ss_runs.size() > 0) ? ss_runs[0] : -1, B_GAP + 1);
    check("b2b.busy_low_runs", busy_runs.size(), 2);
    check("b2b.busy_low_len", (busy_runs.size() > 1) ? busy_runs[1] : -1, 1);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
